// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a prefetch FIFO and a valid/ready decode interface
// Optional HALT_DETECT_EN: stop fetching after enqueuing a HALT_OPCODE word
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef HALT_DETECT_EN
    , parameter logic [4:0] HALT_OPCODE = 5'b10011
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] head_n;
    logic [ADDR_W-1:0] pc;
    logic [PW-1:0] rd, wr, rd_n;
    logic [CW-1:0] count, cnt_n, left;
    logic push, pop, halt_hit;
    always_comb begin
        pop = inst_valid & inst_ready & ~redirect_valid;
        push = ~redirect_valid & ~halted & ((count < CW'(DEPTH)) | pop);
        left = count - CW'(pop);
        cnt_n = redirect_valid ? '0 : left + CW'(push);
        rd_n = rd + PW'(pop);
        // when nothing older survives the pop, the new head is the word being pushed now
        head_n = (left == '0) ? {pc, rom_data} : mem[rd_n];
    end
`ifdef HALT_DETECT_EN
    assign halt_hit = push & (rom_data[15:11] == HALT_OPCODE);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) halted <= 1'b0;
        else halted <= redirect_valid ? 1'b0 : halted | halt_hit;
    end
`else
    assign halt_hit = 1'b0;
    assign halted = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= {pc, rom_data};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
            rd <= '0;
            wr <= '0;
            count <= '0;
            inst_out <= '0;
            inst_pc <= '0;
        end else begin
            pc <= redirect_valid ? redirect_pc : (push & ~halt_hit) ? pc + ADDR_W'(1) : pc;
            rd <= redirect_valid ? '0 : rd_n;
            wr <= redirect_valid ? '0 : wr + PW'(push);
            count <= cnt_n;
            if (cnt_n != '0) {inst_pc, inst_out} <= head_n;
        end
    end
    assign inst_valid = count != '0;
    assign rom_address = pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed ROM words
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] rom_address;
    logic [15:0] rom_data;
    logic redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic inst_valid;
    logic inst_ready = 1'b0;
    logic [15:0] inst_out;
    logic [7:0] inst_pc;
    logic halted;
    int n_checks = 0;
    int n_fail = 0;

    fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .rom_address(rom_address), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (rom_address)
            8'h00: rom_data = 16'hC000;
            8'h01: rom_data = 16'hC801;
            8'h02: rom_data = 16'hD002;
            8'h03: rom_data = 16'hD803;
            8'h0A: rom_data = 16'hC001;
            8'hFE: rom_data = 16'h0000;
            8'hFF: rom_data = 16'h9800;
            default: rom_data = {8'h10, rom_address};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic rdy);
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = rdy;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        start(1'b1);
        reset_n = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
        n_checks++; if (inst_out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got %h exp 0000", inst_out); end
        n_checks++; if (inst_pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h exp 00", inst_pc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_checks++; if (rom_address !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", rom_address); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL cycle1_valid got %b exp 0", inst_valid); end
    endtask

    task automatic test_stream();
        logic [15:0] eo [3] = '{16'hC000, 16'hC801, 16'hD002};
        start(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d got %b exp 1", k, inst_valid); end
            n_checks++; if (inst_out !== eo[k]) begin n_fail++; $display("FAIL stream_out%0d got %h exp %h", k, inst_out, eo[k]); end
            n_checks++; if (inst_pc !== 8'(k)) begin n_fail++; $display("FAIL stream_pc%0d got %h exp %h", k, inst_pc, 8'(k)); end
            n_checks++; if (rom_address !== 8'(k + 1)) begin n_fail++; $display("FAIL stream_addr%0d got %h exp %h", k, rom_address, 8'(k + 1)); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] eo [4] = '{16'hC000, 16'hC801, 16'hD002, 16'hD803};
        start(1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (inst_out !== 16'hC000 || inst_pc !== 8'h00) begin n_fail++; $display("FAIL stall_head%0d got %h@%h exp C000@00", k, inst_out, inst_pc); end
        end
        n_checks++; if (rom_address !== 8'h02) begin n_fail++; $display("FAIL stall_addr got %h exp 02", rom_address); end
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            n_checks++; if (inst_valid !== 1'b1 || inst_out !== eo[k] || inst_pc !== 8'(k)) begin n_fail++; $display("FAIL drain%0d got %b %h@%h exp 1 %h@%h", k, inst_valid, inst_out, inst_pc, eo[k], 8'(k)); end
        end
    endtask

    task automatic test_redirect();
        start(1'b0);
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'h0A;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got %b exp 0", inst_valid); end
        n_checks++; if (rom_address !== 8'h0A) begin n_fail++; $display("FAIL redir_addr got %h exp 0A", rom_address); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_out !== 16'hC001 || inst_pc !== 8'h0A) begin n_fail++; $display("FAIL redir_target got %b %h@%h exp 1 C001@0A", inst_valid, inst_out, inst_pc); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_out !== 16'h100B || inst_pc !== 8'h0B) begin n_fail++; $display("FAIL redir_next got %b %h@%h exp 1 100B@0B", inst_valid, inst_out, inst_pc); end
    endtask

`ifndef HALT_DETECT_EN
    task automatic test_wrap();
        logic [15:0] eo [3] = '{16'h0000, 16'h9800, 16'hC000};
        logic [7:0] ep [3] = '{8'hFE, 8'hFF, 8'h00};
        start(1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (inst_valid !== 1'b1 || inst_out !== eo[k] || inst_pc !== ep[k] || halted !== 1'b0) begin n_fail++; $display("FAIL wrap%0d got %b %h@%h h%b exp 1 %h@%h h0", k, inst_valid, inst_out, inst_pc, halted, eo[k], ep[k]); end
        end
    endtask
`else
    task automatic test_halt();
        start(1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_out !== 16'h9800 || inst_pc !== 8'hFF) begin n_fail++; $display("FAIL halt_word got %b %h@%h exp 1 9800@FF", inst_valid, inst_out, inst_pc); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b exp 1", halted); end
        n_checks++; if (rom_address !== 8'hFF) begin n_fail++; $display("FAIL halt_addr got %h exp FF", rom_address); end
        tick();
        tick();
        n_checks++; if (inst_valid !== 1'b0 || halted !== 1'b1 || rom_address !== 8'hFF) begin n_fail++; $display("FAIL halt_hold got v%b h%b a%h exp v0 h1 aFF", inst_valid, halted, rom_address); end
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %b exp 0", halted); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_out !== 16'hC000 || inst_pc !== 8'h00) begin n_fail++; $display("FAIL halt_resume got %b %h@%h exp 1 C000@00", inst_valid, inst_out, inst_pc); end
    endtask
`endif

    task automatic test_async_reset();
        start(1'b0);
        tick();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b exp 0", inst_valid); end
        n_checks++; if (rom_address !== 8'h00) begin n_fail++; $display("FAIL areset_addr got %h exp 00", rom_address); end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
`ifndef HALT_DETECT_EN
        test_wrap();
`else
        test_halt();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
